psum_accum_fifo: RTL and testbench
==================================

Name: psum_accum_fifo

Overview:
Parametrised multi-lane partial-sum FIFO, the next-generation output/psum buffer of the convolution accelerator.
- Accepts PAR_WRITE psums per push and delivers PAR_READ psums per pop.
- Store mode buffers results unchanged. Accumulate mode adds an incoming psum stream before storing.
- Sits between the PE psum scratchpad and the output read port; replaces the fixed single-lane output buffer plus the separate input-psum buffer.

Parameters:
WIDTH, 16, signed psum word width in bits
ADDR_LEN, 6, address bits; DEPTH = 2**ADDR_LEN words
PAR_WRITE, 2, words pushed per accepted write (1..DEPTH)
PAR_READ, 1, words popped per accepted read (1..DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mode  in  1  0 = store, 1 = accumulate
wen  in  1  write request
din  in  PAR_WRITE*WIDTH  write data; lane 0 = LSBs = oldest word
psum_valid  in  1  psum_in valid
psum_in  in  PAR_WRITE*WIDTH  addend per lane, same lane order as din
psum_ready  out  1  psum_in consumed this cycle
ren  in  1  read request
dout  out  PAR_READ*WIDTH  read data; lane 0 = oldest word
dout_valid  out  1  dout updated this cycle
full  out  1  fewer than PAR_WRITE free slots
empty  out  1  fewer than PAR_READ stored words
count  out  ADDR_LEN+1  stored word count
sat_flag  out  1  sticky saturation indicator

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: wptr = 0, rptr = 0, count = 0, dout = 0, dout_valid = 0, sat_flag = 0. Memory is not cleared. wen and ren are ignored in a reset cycle.
- Reset mid-operation discards all contents. empty = 1 on the cycle after rst.
- full is combinational from count: full = (DEPTH - count) < PAR_WRITE.
- empty is combinational from count: empty = count < PAR_READ.
- push = wen & ~full & (mode==0 | psum_valid).
- psum_ready = mode & wen & ~full. psum_ready does not depend on psum_valid. The psum is consumed only when push is asserted.
- On push, lane k is written to mem[(wptr+k) mod DEPTH], then wptr += PAR_WRITE mod DEPTH.
- Store mode: lane k stores din lane k.
- Accumulate mode: lane k stores din lane k + psum_in lane k, signed WIDTH-bit add.
- pop = ren & ~empty. On pop, dout lane k <= mem[(rptr+k) mod DEPTH], rptr += PAR_READ mod DEPTH.
- Read latency 1: dout_valid is high the cycle after pop, for one cycle. dout holds its value otherwise.
- Simultaneous push and pop are allowed. Each cycle: count <= count + PAR_WRITE*push - PAR_READ*pop.
- full and empty use the pre-update count. A same-cycle pop does not unblock a push.
- A push while full is dropped silently; state is unchanged.
- A pop while empty is dropped silently; dout_valid stays 0.
- mode is sampled every cycle. A mode change affects only subsequent pushes.
- Pointer wrap-around is transparent; lane order is preserved across the wrap.

Optional Feature:
Macro PSUM_SAT_EN.
- Defined: accumulate-mode sums clamp to the signed min/max of WIDTH. Any clamp sets sat_flag, which stays 1 until rst.
- Undefined: sums wrap modulo 2**WIDTH and sat_flag is tied to 0.
- Store mode is identical in both builds.

Test Plan:
1. Store mode, defaults: after reset, push din {lane1=5, lane0=-3}, then 2 pops. Required: dout -3 then 5, dout_valid 1 cycle after each pop, count 2->1->0, empty = 1 at end.
2. Fill: 32 consecutive pushes. Required: count = 64, full = 1. A 33rd wen is dropped with count still 64; psum_ready stays 0 in accumulate mode while full.
3. Accumulate: mode = 1, din lane0 = 100, psum_in lane0 = -30, psum_valid = 1. Required: stored 70, psum_ready = 1. Same request with psum_valid = 0: no push, count unchanged.
4. Saturation, PSUM_SAT_EN defined: 32767 + 1 stores 32767 and -32768 + -1 stores -32768, with sat_flag = 1. Undefined: 32767 + 1 stores -32768, sat_flag = 0.
5. Wrap and concurrency: start at count = 62 with wptr = 62. Push and pop in the same cycle. Required: count 62 -> 63, wptr = 0. Later pops return the wrapped words in write order.
6. Reset mid-operation: after 3 pushes, rst high for 1 cycle. Required: count 0, empty 1, dout_valid 0, sat_flag 0. A following push/pop returns only the post-reset data.

Source files
------------

// File: rtl/psum_accum_fifo.sv
// psum_accum_fifo: multi-lane partial-sum FIFO for the convolution accelerator.
// Pushes PAR_WRITE words per accepted write, pops PAR_READ words per accepted read.
// Store mode buffers din unchanged; accumulate mode stores din + psum_in per lane.
// Optional feature macro: PSUM_SAT_EN (clamp accumulate sums, sticky sat_flag).
// Without PSUM_SAT_EN, sums wrap modulo 2**WIDTH and sat_flag is tied low.
module psum_accum_fifo #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_LEN  = 6,
  parameter int unsigned PAR_WRITE = 2,
  parameter int unsigned PAR_READ  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          wen,
  input  logic [PAR_WRITE*WIDTH-1:0]    din,
  input  logic                          psum_valid,
  input  logic [PAR_WRITE*WIDTH-1:0]    psum_in,
  output logic                          psum_ready,
  input  logic                          ren,
  output logic [PAR_READ*WIDTH-1:0]     dout,
  output logic                          dout_valid,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_LEN:0]             count,
  output logic                          sat_flag
);

  localparam int unsigned DEPTH = 1 << ADDR_LEN;
  localparam int unsigned CW    = ADDR_LEN + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    wdata [PAR_WRITE];
  logic [ADDR_LEN-1:0] wptr;
  logic [ADDR_LEN-1:0] rptr;
  logic [CW-1:0]       free_slots;
  logic [CW-1:0]       count_nxt;
  logic                push;
  logic                pop;

  // Occupancy flags and handshakes, all from the pre-update count
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    full       = free_slots < CW'(PAR_WRITE);
    empty      = count < CW'(PAR_READ);
    psum_ready = mode & wen & ~full;
    push       = ~rst & wen & ~full & (~mode | psum_valid);
    pop        = ~rst & ren & ~empty;
  end

`ifdef PSUM_SAT_EN
  logic [PAR_WRITE-1:0] lane_ovf;
`endif

  // Per-lane write data: pass-through in store mode, signed add in accumulate mode
  for (genvar k = 0; k < int'(PAR_WRITE); k++) begin : g_lane
    logic [WIDTH-1:0] lane_din;
    logic [WIDTH-1:0] lane_psum;
    logic [WIDTH-1:0] lane_acc;

    assign lane_din  = din[k*WIDTH +: WIDTH];
    assign lane_psum = psum_in[k*WIDTH +: WIDTH];

`ifdef PSUM_SAT_EN
    logic [WIDTH:0] sum_ext;
    // One extra bit exposes signed overflow: top two bits differ on overflow
    assign sum_ext     = {lane_din[WIDTH-1], lane_din} + {lane_psum[WIDTH-1], lane_psum};
    assign lane_ovf[k] = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    assign lane_acc    = !lane_ovf[k] ? sum_ext[WIDTH-1:0] :
                         sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                          {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign lane_acc = lane_din + lane_psum;
`endif

    assign wdata[k] = mode ? lane_acc : lane_din;
  end

  // Next occupancy: add pushed words, remove popped words
  always_comb begin
    count_nxt = count;
    if (push) count_nxt = count_nxt + CW'(PAR_WRITE);
    if (pop)  count_nxt = count_nxt - CW'(PAR_READ);
  end

  // Pointers and occupancy; pointer wrap comes for free from ADDR_LEN-bit width
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + ADDR_LEN'(PAR_WRITE);
      if (pop)  rptr <= rptr + ADDR_LEN'(PAR_READ);
      count <= count_nxt;
    end
  end

  // Storage array, lanes written to consecutive slots; contents survive reset
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < int'(PAR_WRITE); k++) begin
        mem[wptr + ADDR_LEN'(k)] <= wdata[k];
      end
    end
  end

  // Registered read port, one-cycle latency, holds value between pops
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= pop;
      if (pop) begin
        for (int k = 0; k < int'(PAR_READ); k++) begin
          dout[k*WIDTH +: WIDTH] <= mem[rptr + ADDR_LEN'(k)];
        end
      end
    end
  end

`ifdef PSUM_SAT_EN
  // Sticky saturation indicator, set by any clamped accumulate push
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (push && mode && (|lane_ovf)) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_psum_accum_fifo.sv
// Randomised self-checking bench for psum_accum_fifo (default parameters).
// Reference model is a word queue plus held dout/sat state.
module tb_psum_accum_fifo;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        wen;
  logic [31:0] din;
  logic        psum_valid;
  logic [31:0] psum_in;
  logic        psum_ready;
  logic        ren;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic [6:0]  count;
  logic        sat_flag;

  psum_accum_fifo #(
    .WIDTH(16), .ADDR_LEN(6), .PAR_WRITE(2), .PAR_READ(1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .wen(wen), .din(din),
    .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(psum_ready),
    .ren(ren), .dout(dout), .dout_valid(dout_valid), .full(full),
    .empty(empty), .count(count), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] q[$];
  logic [15:0] exp_dout = '0;
  bit          exp_dv   = 1'b0;
  bit          exp_sat  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference lane arithmetic: exact integer sum, then clamp or wrap to 16 bits
  function automatic logic [15:0] lane_sum(input logic [15:0] a, input logic [15:0] b,
                                           output bit clamp);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    clamp = 1'b0;
`ifdef PSUM_SAT_EN
    if (s > 32767) begin s = 32767; clamp = 1'b1; end
    else if (s < -32768) begin s = -32768; clamp = 1'b1; end
`endif
    return 16'(s);
  endfunction

  // One clock: drive at negedge, check flags, advance model, check registers
  task automatic step(input bit r, input bit m, input bit w, input logic [31:0] d,
                      input bit pv, input logic [31:0] p, input bit rd);
    bit full_m, empty_m, push_m, pop_m, clamp;
    logic [15:0] word;
    rst = r; mode = m; wen = w; din = d; psum_valid = pv; psum_in = p; ren = rd;
    full_m  = (64 - q.size()) < 2;
    empty_m = q.size() < 1;
    push_m  = !r && w && !full_m && (!m || pv);
    pop_m   = !r && rd && !empty_m;
    #1;
    if (!r) begin
      check("full", 32'(full), 32'(full_m));
      check("empty", 32'(empty), 32'(empty_m));
      check("psum_ready", 32'(psum_ready), 32'(m && w && !full_m));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_dv = 1'b0; exp_dout = '0; exp_sat = 1'b0;
    end else begin
      exp_dv = pop_m;
      if (pop_m) exp_dout = q.pop_front();
      if (push_m) begin
        for (int k = 0; k < 2; k++) begin
          if (m) begin
            word = lane_sum(d[k*16 +: 16], p[k*16 +: 16], clamp);
            if (clamp) exp_sat = 1'b1;
          end else begin
            word = d[k*16 +: 16];
          end
          q.push_back(word);
        end
      end
    end
    @(negedge clk);
    check("count", 32'(count), 32'(q.size()));
    check("dout_valid", 32'(dout_valid), 32'(exp_dv));
    check("dout", 32'(dout), 32'(exp_dout));
    check("sat_flag", 32'(sat_flag), 32'(exp_sat));
  endtask

  task automatic push_store(input logic [31:0] d);
    step(0, 0, 1, d, 0, 32'h0, 0);
  endtask

  task automatic pop_one();
    step(0, 0, 0, 32'h0, 0, 32'h0, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; wen = 1'b0; din = '0;
    psum_valid = 1'b0; psum_in = '0; ren = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_empty", 32'(empty), 32'd1);

    // Store mode: lane1=5, lane0=-3, then two pops
    push_store({16'd5, 16'hFFFD});
    pop_one();
    pop_one();
    check("t1_empty", 32'(empty), 32'd1);

    // Fill to 64 words, then a dropped accumulate push while full
    do_reset();
    for (int i = 0; i < 32; i++) push_store($urandom);
    check("t2_full", 32'(full), 32'd1);
    step(0, 1, 1, $urandom, 1, $urandom, 0);
    for (int i = 0; i < 4; i++) pop_one();

    // Accumulate 100 + -30 = 70, then the same with psum_valid low
    do_reset();
    step(0, 1, 1, {16'd7, 16'd100}, 1, {16'd1, 16'hFFE2}, 0);
    step(0, 1, 1, {16'd7, 16'd100}, 0, {16'd1, 16'hFFE2}, 0);
    pop_one();
    pop_one();

    // Saturation corners: 32767+1 and -32768+-1
    do_reset();
    step(0, 1, 1, {16'h8000, 16'h7FFF}, 1, {16'hFFFF, 16'h0001}, 0);
    pop_one();
    pop_one();

    // Wrap with concurrent push and pop from count 62, wptr 62
    do_reset();
    for (int i = 0; i < 31; i++) push_store($urandom);
    step(0, 0, 1, $urandom, 0, 32'h0, 1);
    step(0, 0, 1, $urandom, 0, 32'h0, 0);
    while (q.size() > 0) pop_one();

    // Reset mid-operation discards contents
    for (int i = 0; i < 3; i++) push_store($urandom);
    do_reset();
    check("t6_empty", 32'(empty), 32'd1);
    push_store({16'h1234, 16'hABCD});
    pop_one();
    pop_one();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 7),
           $urandom, ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
